// File: rtl/riscv_dump_pkg.sv
// Shared types for the architectural state dump unit.
package riscv_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_REGS,
        S_MEM,
        S_STATS,
        S_FINISH
    } dump_state_e;

    localparam logic [1:0] TAG_REG = 2'd0;
    localparam logic [1:0] TAG_MEM = 2'd1;
    localparam logic [1:0] TAG_MIN = 2'd2;
    localparam logic [1:0] TAG_MAX = 2'd3;

endpackage

// File: rtl/state_dump_unit_if.sv
// Dump output stream: valid/ready beats carrying data, tag and index.
interface state_dump_unit_if #(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 10
);
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [1:0]        out_tag;
    logic [MEM_AW-1:0] out_index;

    modport master (
        output out_valid, out_data, out_tag, out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_tag, out_index,
        output out_ready
    );
endinterface

// File: rtl/dump_minmax_acc.sv
// Signed running min/max over sampled words; reads 0/0 until first sample.
module dump_minmax_acc #(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [XLEN-1:0] din,
    output logic signed [XLEN-1:0] min_o,
    output logic signed [XLEN-1:0] max_o
);
    logic signed [XLEN-1:0] min_q, min_d, max_q, max_d;
    logic                   empty_q, empty_d;

    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        empty_d = empty_q;
        if (clr) begin
            min_d   = '0;
            max_d   = '0;
            empty_d = 1'b1;
        end else if (en) begin
            if (empty_q || din < min_q) min_d = din;
            if (empty_q || din > max_q) max_d = din;
            empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q   <= '0;
            max_q   <= '0;
            empty_q <= 1'b1;
        end else begin
            min_q   <= min_d;
            max_q   <= max_d;
            empty_q <= empty_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
endmodule

// File: rtl/state_dump_unit.sv
// Halts the core and streams registers, a memory window and optional
// min/max stats (DUMP_MINMAX_EN) over a valid/ready port.
module state_dump_unit
    import riscv_dump_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int MEM_AW = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MEM_AW-1:0]        base_addr,
    input  logic [MEM_AW-2:0]        word_count,
    output logic                     halt_req,
    input  logic                     halt_ack,
    output logic [$clog2(NREGS)-1:0] rf_raddr,
    input  logic [XLEN-1:0]          rf_rdata,
    output logic [MEM_AW-1:0]        dm_addr,
    input  logic [XLEN-1:0]          dm_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     abort,
    state_dump_unit_if.master        out_if
);
    localparam int RW = $clog2(NREGS);
    localparam logic [RW-1:0] LAST_REG = RW'(NREGS - 1);
`ifdef DUMP_MINMAX_EN
    localparam dump_state_e POST_MEM = S_STATS;
`else
    localparam dump_state_e POST_MEM = S_FINISH;
`endif

    dump_state_e       state_q, state_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [MEM_AW-2:0] cnt_q, cnt_d, k_q, k_d;
    logic [RW-1:0]     idx_q, idx_d;
    logic [MEM_AW-1:0] mem_addr;
    logic              live, valid, fire;

    // Beats are only offered while the core still acknowledges the halt.
    assign live     = state_q inside {S_REGS, S_MEM, S_STATS};
    assign valid    = live && halt_ack;
    assign fire     = valid && out_if.out_ready;
    assign abort    = live && !halt_ack;
    assign busy     = (state_q == S_HALT) || valid;
    assign halt_req = busy;
    assign mem_addr = base_q + {k_q[MEM_AW-3:0], 2'b00};
    assign out_if.out_valid = valid;

`ifdef DUMP_MINMAX_EN
    logic            stat_q, stat_d;
    logic [XLEN-1:0] min_v, max_v;

    dump_minmax_acc #(.XLEN(XLEN)) u_acc (
        .clk   (clk),
        .rst_n (reset),
        .clr   (state_q == S_IDLE && start),
        .en    (fire && state_q == S_MEM),
        .din   (dm_rdata),
        .min_o (min_v),
        .max_o (max_v)
    );
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        idx_d   = idx_q;
`ifdef DUMP_MINMAX_EN
        stat_d  = stat_q;
`endif
        done             = 1'b0;
        rf_raddr         = '0;
        dm_addr          = '0;
        out_if.out_data  = '0;
        out_if.out_tag   = TAG_REG;
        out_if.out_index = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = word_count;
`ifdef DUMP_MINMAX_EN
                    stat_d  = 1'b0;
`endif
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (halt_ack) begin
                    idx_d   = '0;
                    state_d = S_REGS;
                end
            end
            S_REGS: begin
                rf_raddr         = idx_q;
                out_if.out_data  = rf_rdata;
                out_if.out_tag   = TAG_REG;
                out_if.out_index = MEM_AW'(idx_q);
                if (fire) begin
                    if (idx_q == LAST_REG) begin
                        k_d     = '0;
                        state_d = (cnt_q == '0) ? POST_MEM : S_MEM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_MEM: begin
                dm_addr          = mem_addr;
                out_if.out_data  = dm_rdata;
                out_if.out_tag   = TAG_MEM;
                out_if.out_index = mem_addr;
                if (fire) begin
                    if (k_q == cnt_q - 1'b1) state_d = POST_MEM;
                    else                     k_d = k_q + 1'b1;
                end
            end
            S_STATS: begin
`ifdef DUMP_MINMAX_EN
                out_if.out_data  = stat_q ? max_v : min_v;
                out_if.out_tag   = stat_q ? TAG_MAX : TAG_MIN;
                out_if.out_index = base_q;
                if (fire) begin
                    if (stat_q) state_d = S_FINISH;
                    else        stat_d = 1'b1;
                end
`else
                state_d = S_FINISH;
`endif
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
`ifdef DUMP_MINMAX_EN
            stat_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
`ifdef DUMP_MINMAX_EN
            stat_q  <= stat_d;
`endif
        end
    end
endmodule

// File: doc/state_dump_unit.md
STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath word width.
REQ-002 SHALL have parameter NREGS, default 32, register-file entries dumped (x0..x(NREGS-1)).
REQ-003 SHALL have parameter MEM_AW, default 10, data-memory byte-address width.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: start  in  1  dump request pulse; base_addr  in  MEM_AW  word-aligned memory window start; word_count  in  MEM_AW-1  words in window.
REQ-006 SHALL have ports: halt_req  out  1  core halt request; halt_ack  in  1  core halted.
REQ-007 SHALL have ports: rf_raddr  out  clog2(NREGS)  register read address; rf_rdata  in  XLEN  combinational register data.
REQ-008 SHALL have ports: dm_addr  out  MEM_AW  byte address; dm_rdata  in  XLEN  combinational little-endian word at dm_addr..dm_addr+3.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  XLEN; out_tag  out  2  (0 reg, 1 mem, 2 min, 3 max); out_index  out  MEM_AW  register number or byte address.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle completion pulse; abort  out  1  one-cycle abort pulse.

Function
REQ-011 SHALL implement FSM states IDLE, HALT, REGS, MEM, STATS, FINISH.
REQ-012 IDLE: start=1 SHALL latch base_addr/word_count, assert halt_req and busy next cycle, enter HALT; start while busy SHALL be ignored.
REQ-013 HALT: SHALL wait indefinitely for halt_ack=1, then enter REGS with register index 0.
REQ-014 REGS: SHALL drive rf_raddr=index, out_valid=1, out_data=rf_rdata, out_tag=0, out_index=index; SHALL advance index only on out_valid&&out_ready (one beat per cycle max); after index NREGS-1 accepted, enter MEM.
REQ-015 MEM: SHALL drive dm_addr=base_addr+4*k, out_tag=1, out_index=dm_addr, k=0..word_count-1; address SHALL wrap modulo 2^MEM_AW.
REQ-016 word_count=0 SHALL skip MEM entirely.
REQ-017 While out_valid=1 and out_ready=0, out_data/out_tag/out_index/read addresses SHALL remain stable.
REQ-018 FINISH: SHALL deassert halt_req and busy, pulse done for one cycle, return to IDLE.
REQ-019 halt_ack falling while in REGS/MEM/STATS SHALL drop out_valid, release halt_req, pulse abort, return to IDLE without done.
REQ-020 Latency: first beat SHALL be valid the cycle after halt_ack is sampled high; with out_ready held 1, total beats SHALL take NREGS+word_count(+2) consecutive cycles.

Reset
REQ-021 Asserted reset SHALL immediately force IDLE, halt_req=0, busy=0, out_valid=0, done=0, abort=0, out_data=0, out_tag=0, out_index=0, rf_raddr=0, dm_addr=0, even mid-dump.

Configuration
REQ-022 With DUMP_MINMAX_EN defined, SHALL track signed XLEN min/max over MEM words accepted and, in STATS, emit min (tag 2) then max (tag 3), out_index=base_addr; word_count=0 SHALL emit min=0, max=0.
REQ-023 Without DUMP_MINMAX_EN, STATS SHALL be bypassed (MEM to FINISH), tags 2/3 never produced, no accumulator logic present.

Structure
REQ-024 Package riscv_dump_pkg SHALL hold the FSM state enum and tag constants TAG_REG, TAG_MEM, TAG_MIN, TAG_MAX.
REQ-025 Min/max accumulation SHALL be sub-module dump_minmax_acc (clear, sample-enable, data in; min/max out), instantiated only under DUMP_MINMAX_EN.

Verification
REQ-026 Reset mid-MEM (beat 5) -> next cycle all outputs at reset values, halt_req=0; later start works normally.
REQ-027 NREGS=32, word_count=4, base_addr=0x28, out_ready=1, halt_ack one cycle after halt_req -> 36 beats: regs 0..31, then mem at 0x28,0x2C,0x30,0x34, then done pulse.
REQ-028 out_ready toggling 1,0,0,1 during REGS -> no beat duplicated or dropped, data stable during stalls.
REQ-029 MEM_AW=10, base_addr=0x3F8, word_count=4 -> addresses 0x3F8,0x3FC,0x000,0x004.
REQ-030 DUMP_MINMAX_EN, window words {5, -3, 0x7FFFFFFF, 2} -> tag2=0xFFFFFFFD, tag3=0x7FFFFFFF; without macro no tag2/3 beats.
REQ-031 halt_ack dropped at register 10 -> abort pulse, out_valid=0, halt_req=0, no done; start during dump ignored.
